// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator call scheduler.
// Floors are numbered from 1, and pending bit (floor-1) belongs to that floor.
package elev_pkg;

  localparam int FLOOR_W       = 4;
  localparam int DOOR_TIME_DEF = 100;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  function automatic logic [FLOOR_W-1:0] floor_idx(input logic [FLOOR_W-1:0] floor);
    return floor - FLOOR_W'(1);
  endfunction

endpackage

// File: rtl/elevator_sched_if.sv
// Signal bundle between the scheduler, the call buttons and the floor-motion block.
// The slave modport is the scheduler's view of the bundle.
interface elevator_sched_if #(
  parameter int FLOORS = 8
);
  import elev_pkg::*;

  logic [FLOORS-1:0]  call_btn;
  logic [FLOOR_W-1:0] now_floor;
  logic               arr;
  logic [FLOOR_W-1:0] des_floor;
  logic               dir_up;
  logic               door_open;
  logic [FLOORS-1:0]  pending;
  logic               busy;

  modport slave (
    input  call_btn, now_floor, arr,
    output des_floor, dir_up, door_open, pending, busy
  );

  modport master (
    output call_btn, now_floor, arr,
    input  des_floor, dir_up, door_open, pending, busy
  );

endinterface

// File: rtl/elev_target_pick.sv
// Finds the nearest pending floor above and below the car.
// The car's current floor is never returned as a target.
module elev_target_pick
  import elev_pkg::*;
#(
  parameter int FLOORS = 8
) (
  input  logic [FLOORS-1:0]  pending,
  input  logic [FLOOR_W-1:0] now_floor,
  output logic [FLOOR_W-1:0] up_tgt,
  output logic               up_vld,
  output logic [FLOOR_W-1:0] dn_tgt,
  output logic               dn_vld
);

  // Scanning downward leaves the lowest hit above the car; scanning upward leaves the highest hit below it.
  always_comb begin
    up_tgt = '0;
    up_vld = 1'b0;
    dn_tgt = '0;
    dn_vld = 1'b0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && ((i + 1) > int'(now_floor))) begin
        up_tgt = FLOOR_W'(i + 1);
        up_vld = 1'b1;
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && ((i + 1) < int'(now_floor))) begin
        dn_tgt = FLOOR_W'(i + 1);
        dn_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_sched.sv
// SCAN call scheduler: latches calls, picks the next destination and times the door dwell.
// Floor motion is done externally; this block only issues des_floor and watches arr.
module elevator_sched
  import elev_pkg::*;
#(
  parameter int FLOORS    = 8,
  parameter int DOOR_TIME = DOOR_TIME_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  elevator_sched_if.slave bus
);

  localparam int CNT_W = $clog2(DOOR_TIME + 1);

  state_t             state;
  logic [CNT_W-1:0]   door_cnt;
  logic [FLOORS-1:0]  pending_q;
  logic [FLOOR_W-1:0] des_q;
  logic               dir_up_q;
  logic               door_q;
  logic               busy_q;
  logic               move_seen;
  logic               upd_last;

  logic [FLOOR_W-1:0] up_tgt;
  logic [FLOOR_W-1:0] dn_tgt;
  logic               up_vld;
  logic               dn_vld;

  logic               floor_ok;
  logic [FLOORS-1:0]  here_mask;
  logic [FLOORS-1:0]  call_mask;
  logic [FLOORS-1:0]  clr_mask;
  logic               here_pend;
  logic               here_call;
  logic               door_from_idle;
  logic               arrive;
  logic               intercept;

  elev_target_pick #(
    .FLOORS(FLOORS)
  ) u_pick (
    .pending  (pending_q),
    .now_floor(bus.now_floor),
    .up_tgt   (up_tgt),
    .up_vld   (up_vld),
    .dn_tgt   (dn_tgt),
    .dn_vld   (dn_vld)
  );

  assign floor_ok  = (bus.now_floor != '0) && (bus.now_floor <= FLOOR_W'(FLOORS));
  assign here_mask = floor_ok ? ({{(FLOORS-1){1'b0}}, 1'b1} << floor_idx(bus.now_floor)) : '0;
  assign here_pend = |(pending_q & here_mask);
  assign here_call = |(bus.call_btn & here_mask);

  assign door_from_idle = (state == IDLE) && here_pend;

  // Arrival ignores arr until it can reflect the current destination, since arr lags by one cycle.
  assign arrive = (state == MOVE) && bus.arr && (bus.now_floor == des_q) && move_seen && !upd_last;

  assign intercept = (state == MOVE) && floor_ok &&
                     (dir_up_q ? (up_vld && (up_tgt < des_q)) : (dn_vld && (dn_tgt > des_q)));

  // A call at the open door only extends the dwell; a floor being served drops its call.
  assign call_mask = (state == DOOR) ? (bus.call_btn & ~here_mask) : bus.call_btn;
  assign clr_mask  = (door_from_idle || arrive) ? here_mask : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending_q <= '0;
      des_q     <= FLOOR_W'(1);
      dir_up_q  <= 1'b1;
      door_q    <= 1'b0;
      busy_q    <= 1'b0;
      door_cnt  <= '0;
      move_seen <= 1'b0;
      upd_last  <= 1'b0;
    end else begin
      pending_q <= (pending_q | call_mask) & ~clr_mask;
      case (state)
        IDLE: begin
          door_q   <= 1'b0;
          door_cnt <= '0;
          if (floor_ok) begin
            des_q <= bus.now_floor;
            if (here_pend) begin
              state  <= DOOR;
              door_q <= 1'b1;
              busy_q <= 1'b1;
            end else if (up_vld && (dir_up_q || !dn_vld)) begin
              state     <= MOVE;
              des_q     <= up_tgt;
              dir_up_q  <= 1'b1;
              busy_q    <= 1'b1;
              move_seen <= 1'b0;
              upd_last  <= 1'b0;
            end else if (dn_vld) begin
              state     <= MOVE;
              des_q     <= dn_tgt;
              dir_up_q  <= 1'b0;
              busy_q    <= 1'b1;
              move_seen <= 1'b0;
              upd_last  <= 1'b0;
            end
          end
        end
        MOVE: begin
          move_seen <= 1'b1;
          if (!floor_ok) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (arrive) begin
            state    <= DOOR;
            door_q   <= 1'b1;
            door_cnt <= '0;
            upd_last <= 1'b0;
          end else if (intercept) begin
            des_q    <= dir_up_q ? up_tgt : dn_tgt;
            upd_last <= 1'b1;
          end else begin
            upd_last <= 1'b0;
          end
        end
        DOOR: begin
          if (!floor_ok) begin
            state    <= IDLE;
            door_q   <= 1'b0;
            busy_q   <= 1'b0;
            door_cnt <= '0;
          end else if (here_call) begin
            door_cnt <= '0;
          end else if (door_cnt == CNT_W'(DOOR_TIME - 1)) begin
            state    <= IDLE;
            door_q   <= 1'b0;
            busy_q   <= 1'b0;
            door_cnt <= '0;
          end else begin
            door_cnt <= door_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          door_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.des_floor = des_q;
  assign bus.dir_up    = dir_up_q;
  assign bus.door_open = door_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = busy_q;

endmodule
